// File: rtl/data_delay_ctrl.sv
// IDELAY tap loader: pulses delay_data_reset to load a new tap into every lane,
// waits for the lines to settle, verifies the readback and retries on mismatch.
module data_delay_ctrl #(
    parameter int NUM_LANES     = 13,
    parameter int TAP_WIDTH     = 5,
    parameter int PULSE_CYCLES  = 5,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRIES   = 11
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [TAP_WIDTH-1:0]           delay_tap,
    input  logic [NUM_LANES*TAP_WIDTH-1:0] wiz_delay_tap,
    input  logic                           force_load,
    output logic                           delay_data_reset,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [NUM_LANES-1:0]           error_lanes,
    output logic [7:0]                     retry_count
);

    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

    localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] RETRY_MAX   = 8'(MAX_RETRIES);

    state_t                 state_q, state_d;
    logic [TAP_WIDTH-1:0]   applied_tap_q, applied_tap_d;
    logic [TAP_WIDTH-1:0]   target_tap_q, target_tap_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             retry_count_q, retry_count_d;
    logic                   ddr_q, ddr_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [NUM_LANES-1:0]   error_lanes_q, error_lanes_d;
    logic [NUM_LANES-1:0]   mismatch;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign mismatch[g] = (wiz_delay_tap[g*TAP_WIDTH +: TAP_WIDTH] != target_tap_q);
    end

    always_comb begin
        state_d       = state_q;
        applied_tap_d = applied_tap_q;
        target_tap_d  = target_tap_q;
        cnt_d         = cnt_q;
        retry_count_d = retry_count_q;
        ddr_d         = ddr_q;
        done_d        = 1'b0;
        error_d       = error_q;
        error_lanes_d = error_lanes_q;
        case (state_q)
            IDLE: begin
                if ((delay_tap != applied_tap_q) || force_load) begin
                    target_tap_d  = delay_tap;
                    cnt_d         = '0;
                    retry_count_d = '0;
                    error_d       = 1'b0;
                    error_lanes_d = '0;
                    ddr_d         = 1'b1;
                    state_d       = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    ddr_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CHECK: begin
                if (mismatch == '0) begin
                    applied_tap_d = target_tap_q;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end else if (retry_count_q < RETRY_MAX) begin
                    retry_count_d = retry_count_q + 8'd1;
                    cnt_d         = '0;
                    ddr_d         = 1'b1;
                    state_d       = PULSE;
                end else begin
                    // Give up but record the tap as applied so a stuck lane
                    // does not cause an endless reload loop.
                    error_d       = 1'b1;
                    error_lanes_d = mismatch;
                    applied_tap_d = target_tap_q;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            applied_tap_q <= '0;
            target_tap_q  <= '0;
            cnt_q         <= '0;
            retry_count_q <= '0;
            ddr_q         <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            error_lanes_q <= '0;
        end else begin
            state_q       <= state_d;
            applied_tap_q <= applied_tap_d;
            target_tap_q  <= target_tap_d;
            cnt_q         <= cnt_d;
            retry_count_q <= retry_count_d;
            ddr_q         <= ddr_d;
            done_q        <= done_d;
            error_q       <= error_d;
            error_lanes_q <= error_lanes_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign delay_data_reset = ddr_q;
    assign done             = done_q;
    assign error            = error_q;
    assign error_lanes      = error_lanes_q;
    assign retry_count      = retry_count_q;

endmodule

// File: tb/tb_data_delay_ctrl.sv
// Randomized bench for data_delay_ctrl: per-lane readback behaviour is described as
// "fails the first N checks"; expected attempts, timing and error mask follow arithmetically.
module tb_data_delay_ctrl;
    localparam int NL = 13;
    localparam int TW = 5;
    localparam int P  = 5;
    localparam int S  = 2;
    localparam int MR = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic [TW-1:0]     delay_tap;
    logic [NL*TW-1:0]  wiz_delay_tap;
    logic              force_load;
    logic              delay_data_reset, busy, done, error;
    logic [NL-1:0]     error_lanes;
    logic [7:0]        retry_count;

    int checks = 0;
    int errors = 0;
    int fail_until [NL];

    data_delay_ctrl #(.NUM_LANES(NL), .TAP_WIDTH(TW), .PULSE_CYCLES(P),
                      .SETTLE_CYCLES(S), .MAX_RETRIES(MR)) dut (
        .clk(clk), .reset(reset), .delay_tap(delay_tap), .wiz_delay_tap(wiz_delay_tap),
        .force_load(force_load), .delay_data_reset(delay_data_reset), .busy(busy),
        .done(done), .error(error), .error_lanes(error_lanes), .retry_count(retry_count)
    );

    always #10 clk = ~clk;

    task automatic clear_fails();
        for (int l = 0; l < NL; l++) fail_until[l] = 0;
    endtask

    // Starts (or follows an already-started) sequence and checks it against the model.
    // mid_ev: 0 none, 1 force_load during PULSE, 2 delay_tap change during SETTLE.
    task automatic run_seq(input string name, input logic [TW-1:0] tap, input bit frc,
                           input int mid_ev, input logic [TW-1:0] mid_tap, input bit quiet);
        int rises = 0, first = -1, dn = -1, run = 0, wbad = 0, worst = 0, att, extra;
        bit prev = 1'b0, busy_at_rise = 1'b0;
        logic [NL-1:0] exp_mask = '0;
        logic [TW-1:0] bad = tap + 5'd1;
        for (int l = 0; l < NL; l++) if (fail_until[l] > worst) worst = fail_until[l];
        if (worst + 1 <= MR + 1) att = worst + 1;
        else begin
            att = MR + 1;
            for (int l = 0; l < NL; l++) exp_mask[l] = (fail_until[l] >= MR + 1);
        end
        delay_tap  = tap;
        force_load = frc;
        for (int i = 0; i < 400 && dn < 0; i++) begin
            @(negedge clk);
            force_load = 1'b0;
            if (delay_data_reset && !prev) begin
                rises++;
                if (first < 0) begin first = i; busy_at_rise = busy; end
                for (int l = 0; l < NL; l++)
                    wiz_delay_tap[l*TW +: TW] = (rises <= fail_until[l]) ? bad : tap;
            end
            if (delay_data_reset) run++;
            else begin
                if (prev && run != P) wbad++;
                run = 0;
            end
            if (first >= 0 && i == first + 2 && mid_ev == 1) force_load = 1'b1;
            if (first >= 0 && i == first + 6 && mid_ev == 2) delay_tap = mid_tap;
            if (done) dn = i;
            prev = delay_data_reset;
        end
        checks++;
        if (dn < 0) begin
            errors++; $display("FAIL %s timeout: done never seen, required within 400 clocks", name);
            return;
        end
        checks++;
        if (first !== 0) begin errors++; $display("FAIL %s start: first pulse at clock %0d, required 0", name, first); end
        checks++;
        if (busy_at_rise !== 1'b1) begin errors++; $display("FAIL %s busy: got %b at first pulse, required 1", name, busy_at_rise); end
        checks++;
        if (rises != att) begin errors++; $display("FAIL %s pulses: got %0d, required %0d", name, rises, att); end
        checks++;
        if (wbad != 0) begin errors++; $display("FAIL %s width: %0d pulses not %0d clocks wide", name, wbad, P); end
        checks++;
        if (dn - first != att * (P + S + 1)) begin
            errors++; $display("FAIL %s latency: got %0d, required %0d", name, dn - first, att * (P + S + 1));
        end
        checks++;
        if (error !== (exp_mask != '0)) begin errors++; $display("FAIL %s error: got %b, required %b", name, error, exp_mask != '0); end
        checks++;
        if (error_lanes !== exp_mask) begin errors++; $display("FAIL %s error_lanes: got %h, required %h", name, error_lanes, exp_mask); end
        checks++;
        if (retry_count !== 8'(att - 1)) begin errors++; $display("FAIL %s retry_count: got %0d, required %0d", name, retry_count, att - 1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s idle: busy got %b at done, required 0", name, busy); end
        if (quiet) begin
            extra = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (delay_data_reset || done || busy) extra++;
            end
            checks++;
            if (extra != 0) begin errors++; $display("FAIL %s quiet: %0d active clocks after done, required 0", name, extra); end
            checks++;
            if (error !== (exp_mask != '0)) begin errors++; $display("FAIL %s error hold: got %b, required %b", name, error, exp_mask != '0); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; delay_tap = 5'($urandom); force_load = 1'b1;
        wiz_delay_tap = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({delay_data_reset, busy, done, error, error_lanes, retry_count} !== '0) begin
            errors++; $display("FAIL reset outputs: got %b %b %b %b %h %0d, required all zero",
                               delay_data_reset, busy, done, error, error_lanes, retry_count);
        end
        delay_tap = '0; force_load = 1'b0; reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (delay_data_reset !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset idle: ddr %b busy %b with tap 0, required 0 0", delay_data_reset, busy);
        end
    endtask

    task automatic test_basic();
        clear_fails();
        run_seq("basic", 5'd7, 1'b0, 0, 5'd0, 1'b1);
    endtask

    task automatic test_retry();
        clear_fails();
        fail_until[3] = 2;
        run_seq("retry", 5'd7, 1'b1, 0, 5'd0, 1'b1);
    endtask

    task automatic test_exhaust();
        clear_fails();
        fail_until[12] = 1000;
        run_seq("exhaust", 5'd9, 1'b0, 0, 5'd0, 1'b1);
    endtask

    task automatic test_force();
        clear_fails();
        run_seq("force", 5'd9, 1'b1, 1, 5'd0, 1'b1);
    endtask

    task automatic test_reset_mid_pulse();
        delay_tap = 5'd5;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (delay_data_reset !== 1'b0 || busy !== 1'b0 || retry_count !== 8'd0 || error !== 1'b0) begin
            errors++; $display("FAIL mid reset: ddr %b busy %b rc %0d err %b, required 0 0 0 0",
                               delay_data_reset, busy, retry_count, error);
        end
        reset = 1'b0;
        clear_fails();
        run_seq("after reset", 5'd7, 1'b0, 0, 5'd0, 1'b1);
    endtask

    task automatic test_tap_change();
        clear_fails();
        run_seq("change 12", 5'd12, 1'b0, 0, 5'd0, 1'b1);
        run_seq("change first", 5'd7, 1'b0, 2, 5'd12, 1'b0);
        run_seq("change second", 5'd12, 1'b0, 0, 5'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [TW-1:0] applied = 5'd12;
        logic [TW-1:0] tap;
        for (int n = 0; n < 8; n++) begin
            clear_fails();
            tap = 5'($urandom);
            for (int l = 0; l < NL; l++)
                if ($urandom_range(3) == 0) fail_until[l] = $urandom_range(4, 1);
            if ($urandom_range(3) == 0) fail_until[$urandom_range(NL - 1)] = 1000;
            run_seq("random", tap, (tap == applied) || ($urandom_range(1) == 1), 0, 5'd0, 1'b1);
            applied = tap;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retry();
        test_exhaust();
        test_force();
        test_reset_mid_pulse();
        test_tap_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_delay_ctrl.md
DATA_DELAY_CTRL -- requirements
Module: data_delay_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 13, number of IDELAY data lanes.
REQ-002 SHALL have parameter TAP_WIDTH, default 5, tap value width per lane.
REQ-003 SHALL have parameter PULSE_CYCLES, default 5, delay_data_reset high time in clocks (legal 1..255).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2, wait after pulse before tap check (legal 1..255).
REQ-005 SHALL have parameter MAX_RETRIES, default 11, retries after the first failed check (legal 0..255).
REQ-006 SHALL have port clk  input  1  single clock, 50 MHz or lower.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port delay_tap  input  TAP_WIDTH  requested tap from register block.
REQ-009 SHALL have port wiz_delay_tap  input  NUM_LANES*TAP_WIDTH  tap readback; lane i at bits [i*TAP_WIDTH +: TAP_WIDTH].
REQ-010 SHALL have port force_load  input  1  one-cycle request to re-apply the current tap.
REQ-011 SHALL have port delay_data_reset  output  1  registered active-high load pulse to the delay lines.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a sequence ends (pass or fail).
REQ-014 SHALL have port error  output  1  last sequence exhausted its retries.
REQ-015 SHALL have port error_lanes  output  NUM_LANES  lanes mismatching at final failed check.
REQ-016 SHALL have port retry_count  output  8  retries used by the current/last sequence.

Function
REQ-017 SHALL implement states IDLE, PULSE, SETTLE, CHECK, with internal applied_tap, target_tap and an 8-bit counter.
REQ-018 In IDLE, if delay_tap != applied_tap or force_load=1, SHALL latch target_tap<=delay_tap, clear counter, retry_count, error and error_lanes, set delay_data_reset=1 and go to PULSE; the simultaneous condition starts one sequence only.
REQ-019 In PULSE, SHALL hold delay_data_reset=1 for exactly PULSE_CYCLES clocks, then clear it, clear counter and enter SETTLE.
REQ-020 In SETTLE, SHALL hold delay_data_reset=0 for exactly SETTLE_CYCLES clocks, then enter CHECK.
REQ-021 In CHECK (one clock), SHALL compare every lane slice to target_tap and form a mismatch mask.
REQ-022 If mask is zero, SHALL set applied_tap<=target_tap, pulse done, return to IDLE with error=0.
REQ-023 If mask is nonzero and retry_count < MAX_RETRIES, SHALL increment retry_count, set delay_data_reset=1 and re-enter PULSE.
REQ-024 If mask is nonzero and retry_count = MAX_RETRIES, SHALL set error=1, error_lanes<=mask, applied_tap<=target_tap, pulse done, return to IDLE.
REQ-025 Pass latency, delay_data_reset rising edge to done rising edge, SHALL be PULSE_CYCLES+SETTLE_CYCLES+1 clocks; each retry SHALL add the same amount.
REQ-026 Changes of delay_tap and force_load outside IDLE SHALL be ignored; a differing delay_tap SHALL start a new sequence on the first IDLE cycle after return.
REQ-027 error and error_lanes SHALL hold until the next sequence start or reset.
REQ-028 All outputs SHALL be registered except busy, which SHALL be decoded from state.

Reset
REQ-029 On reset=1 at a clock edge, from any state including mid-sequence, SHALL force state=IDLE, applied_tap=0, target_tap=0, counter=0, delay_data_reset=0, done=0, error=0, error_lanes=0, retry_count=0.
REQ-030 After reset, a nonzero delay_tap SHALL start a sequence on the first non-reset clock.

Verification (defaults)
REQ-031 delay_tap 0->7, readback all lanes 7 after pulse -> delay_data_reset high exactly 5 clocks, done 8 clocks after its rise, error=0, retry_count=0.
REQ-032 delay_tap=7, lane 3 reads 6 for first two checks then 7 -> two extra pulses, retry_count=2, done 24 clocks after first rise, error=0.
REQ-033 delay_tap=9, lane 12 never matches -> 12 pulses total, done 96 clocks after first rise, error=1, error_lanes=0x1000, retry_count=11, then no further pulses while delay_tap stays 9.
REQ-034 force_load pulse in IDLE with taps matching -> one 5-clock pulse, done, error=0; force_load during PULSE -> ignored.
REQ-035 reset asserted during PULSE -> next clock delay_data_reset=0, busy=0; after release, delay_tap=7 starts a fresh sequence.
REQ-036 delay_tap changed 7->12 during SETTLE -> current sequence completes against 7, then a new sequence targets 12.
